// File: rtl/estufa_ctrl.sv
// rtl/estufa_ctrl.sv - greenhouse climate FSM with minimum run time, dead time and filtered sensor fault
// Heater/cooler/fault are decoded from the state register, so each follows the inputs by one edge.
module estufa_ctrl #(
  parameter int MIN_ON     = 4,
  parameter int DEAD       = 2,
  parameter int FAULT_FILT = 3,
  parameter int CNT_W      = 8
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       t1,
  input  logic       t2,
  input  logic       ack,
  output logic       heater,
  output logic       cooler,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] n_starts
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAT  = 3'd1,
    S_COOL  = 3'd2,
    S_DEAD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FAULT_FILT - 1);
  localparam logic [CNT_W-1:0] FILT_MAX  = CNT_W'(FAULT_FILT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] dead_cnt_q, dead_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
  logic [7:0]       n_starts_q, n_starts_d;

  logic heat_req, cool_req, bad, fault_trip, own_req;

  assign heat_req   = ~t1 & ~t2;
  assign cool_req   =  t1 &  t2;
  assign bad        = ~t1 &  t2;
  assign fault_trip = bad && (bad_cnt_q == FILT_LAST);

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q    <= S_IDLE;
      run_cnt_q  <= '0;
      dead_cnt_q <= '0;
      bad_cnt_q  <= '0;
      n_starts_q <= '0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      n_starts_q <= n_starts_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    dead_cnt_d = dead_cnt_q;
    n_starts_d = n_starts_q;
    own_req    = (state_q == S_HEAT) ? heat_req : cool_req;
    if (bad) begin
      bad_cnt_d = (bad_cnt_q == FILT_MAX) ? bad_cnt_q : bad_cnt_q + CNT_ONE;
    end else begin
      bad_cnt_d = '0;
    end

    // The fault filter pre-empts every other transition, including an unfinished run.
    if (fault_trip && state_q != S_FAULT) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (heat_req || cool_req) begin
            state_d    = heat_req ? S_HEAT : S_COOL;
            run_cnt_d  = '0;
            n_starts_d = n_starts_q + 8'd1;
          end
        end
        S_HEAT, S_COOL: begin
          if (run_cnt_q == RUN_LAST) begin
            if (!own_req) begin
              state_d    = S_DEAD;
              dead_cnt_d = '0;
            end
          end else begin
            run_cnt_d = run_cnt_q + CNT_ONE;
          end
        end
        S_DEAD: begin
          if (dead_cnt_q == DEAD_LAST) begin
            state_d = S_IDLE;
          end else begin
            dead_cnt_d = dead_cnt_q + CNT_ONE;
          end
        end
        S_FAULT: begin
          if (ack && !bad) begin
            state_d   = S_IDLE;
            bad_cnt_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    heater   = (state_q == S_HEAT);
    cooler   = (state_q == S_COOL);
    fault    = (state_q == S_FAULT);
    state    = state_q;
    n_starts = n_starts_q;
  end

endmodule

// File: tb/tb_estufa_ctrl.sv
// tb/tb_estufa_ctrl.sv - directed-vector bench for estufa_ctrl (default and minimal-parameter builds)
module tb_estufa_ctrl;

  logic clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  logic       reset, t1, t2, ack;
  logic       heater, cooler, fault;
  logic [2:0] state;
  logic [7:0] n_starts;

  logic       r1, a1, b1, k1;
  logic       heater1, cooler1, fault1;
  logic [2:0] state1;
  logic [7:0] n_starts1;

  int n_cmp = 0;
  int n_err = 0;

  estufa_ctrl dut (
    .clk_2(clk_2), .reset(reset), .t1(t1), .t2(t2), .ack(ack),
    .heater(heater), .cooler(cooler), .fault(fault), .state(state), .n_starts(n_starts)
  );

  estufa_ctrl #(.MIN_ON(1), .DEAD(1), .FAULT_FILT(1), .CNT_W(8)) dut1 (
    .clk_2(clk_2), .reset(r1), .t1(a1), .t2(b1), .ack(k1),
    .heater(heater1), .cooler(cooler1), .fault(fault1), .state(state1), .n_starts(n_starts1)
  );

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; t1 = 1'b1; t2 = 1'b0; ack = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; t1 = 1'b0; t2 = 1'b0; ack = 1'b1;
    step();
    n_cmp++;
    if ({state, heater, cooler, fault, n_starts} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_state: got state=%0d h=%b c=%b f=%b n=%0d, want all 0",
               state, heater, cooler, fault, n_starts);
    end
    t1 = 1'b1; ack = 1'b0;
    reset = 1'b0;
    step();
    n_cmp++;
    if (state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_idle_ok: got state=%0d want 0", state);
    end
  endtask

  task automatic test_heat_cycle();
    logic [2:0] exp_s [7];
    logic [5:0] got, want;
    exp_s = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      t1 = (i != 0); t2 = 1'b0;
      step();
      got  = {state, heater, cooler, fault};
      want = {exp_s[i], exp_s[i] == 3'd1, exp_s[i] == 3'd2, exp_s[i] == 3'd4};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL heat_cycle edge %0d: got {st,h,c,f}=%b want %b", i + 1, got, want);
      end
    end
    n_cmp++;
    if (n_starts !== 8'd1) begin
      n_err++;
      $display("FAIL heat_cycle_starts: got %0d want 1", n_starts);
    end
  endtask

  task automatic test_heat_to_cool();
    logic [2:0] exp_s [10];
    logic [5:0] got, want;
    exp_s = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd0, 3'd2, 3'd2, 3'd2};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      t1 = (i != 0); t2 = (i != 0);
      step();
      got  = {state, heater, cooler, fault};
      want = {exp_s[i], exp_s[i] == 3'd1, exp_s[i] == 3'd2, exp_s[i] == 3'd4};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL heat_to_cool edge %0d: got {st,h,c,f}=%b want %b", i + 1, got, want);
      end
    end
    n_cmp++;
    if (n_starts !== 8'd2) begin
      n_err++;
      $display("FAIL heat_to_cool_starts: got %0d want 2", n_starts);
    end
  endtask

  task automatic test_fault_filter();
    logic [1:0] tin   [11];
    logic [2:0] exp_s [11];
    logic [5:0] got, want;
    tin   = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    exp_s = '{3'd0,  3'd0,  3'd0,  3'd0,  3'd0,  3'd0,  3'd1,  3'd1,  3'd1,  3'd1,  3'd4};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      {t1, t2} = tin[i];
      step();
      got  = {state, heater, cooler, fault};
      want = {exp_s[i], exp_s[i] == 3'd1, exp_s[i] == 3'd2, exp_s[i] == 3'd4};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL fault_filter edge %0d: got {st,h,c,f}=%b want %b", i + 1, got, want);
      end
    end
  endtask

  task automatic test_fault_ack();
    logic [2:0] ain   [7];
    logic [2:0] exp_s [7];
    logic [5:0] got, want;
    ain   = '{3'b101, 3'b010, 3'b001, 3'b110, 3'b110, 3'b100, 3'b010};
    exp_s = '{3'd4,   3'd4,   3'd4,   3'd0,   3'd0,   3'd1,   3'd1};
    for (int i = 0; i < 7; i++) begin
      {ack, t1, t2} = ain[i];
      step();
      got  = {state, heater, cooler, fault};
      want = {exp_s[i], exp_s[i] == 3'd1, exp_s[i] == 3'd2, exp_s[i] == 3'd4};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL fault_ack edge %0d: got {st,h,c,f}=%b want %b", i + 1, got, want);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    t1 = 1'b1; t2 = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (state !== 3'd2 || cooler !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_precool: got state=%0d c=%b want 2,1", state, cooler);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if ({state, cooler, n_starts} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_mid_cool: got state=%0d c=%b n=%0d want 0,0,0", state, cooler, n_starts);
    end
    t1 = 1'b0; t2 = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (state !== 3'd4 || fault !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_prefault: got state=%0d f=%b want 4,1", state, fault);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_fault: got state=%0d f=%b want 0,0", state, fault);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 1; k <= 256; k++) begin
      t1 = 1'b0; t2 = 1'b0;
      step();
      t1 = 1'b1;
      repeat (6) step();
      if (k == 255) begin
        n_cmp++;
        if (n_starts !== 8'd255 || state !== 3'd0) begin
          n_err++;
          $display("FAIL wrap_255: got n=%0d state=%0d want 255,0", n_starts, state);
        end
      end
    end
    n_cmp++;
    if (n_starts !== 8'd0) begin
      n_err++;
      $display("FAIL wrap_0: got n=%0d want 0", n_starts);
    end
  endtask

  task automatic test_min_build();
    logic [2:0] ain   [10];
    logic [2:0] exp_s [10];
    logic [5:0] got, want;
    ain   = '{3'b000, 3'b010, 3'b010, 3'b001, 3'b001, 3'b110, 3'b100, 3'b100, 3'b110, 3'b110};
    exp_s = '{3'd1,   3'd3,   3'd0,   3'd4,   3'd4,   3'd0,   3'd1,   3'd1,   3'd3,   3'd0};
    r1 = 1'b1; a1 = 1'b1; b1 = 1'b0; k1 = 1'b0;
    step();
    r1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      {k1, a1, b1} = ain[i];
      step();
      got  = {state1, heater1, cooler1, fault1};
      want = {exp_s[i], exp_s[i] == 3'd1, exp_s[i] == 3'd2, exp_s[i] == 3'd4};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL min_build edge %0d: got {st,h,c,f}=%b want %b", i + 1, got, want);
      end
    end
    n_cmp++;
    if (n_starts1 !== 8'd2) begin
      n_err++;
      $display("FAIL min_build_starts: got %0d want 2", n_starts1);
    end
  endtask

  initial begin
    reset = 1'b1; t1 = 1'b1; t2 = 1'b0; ack = 1'b0;
    r1 = 1'b1; a1 = 1'b1; b1 = 1'b0; k1 = 1'b0;
    test_reset();
    test_heat_cycle();
    test_heat_to_cool();
    test_fault_filter();
    test_fault_ack();
    test_reset_mid();
    test_wrap();
    test_min_build();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/estufa_ctrl.md
Name: estufa_ctrl

Overview:
Sequential climate controller for the greenhouse (estufa) board exercise. Replaces the purely combinational sensor→actuator decode with an FSM that enforces a minimum actuator run time and a dead-time gap between heating and cooling. It also filters inconsistent sensor readings into a latched fault that needs an explicit acknowledge. It sits between the switch-driven sensor inputs (t1 = SWI[7], t2 = SWI[6]) and the LED/SEG actuator outputs in top.

Parameters:
MIN_ON, 4, minimum number of cycles HEAT or COOL stays active once entered (≥1)
DEAD, 2, cycles both actuators are forced off after HEAT/COOL ends (≥1)
FAULT_FILT, 3, consecutive inconsistent samples required to latch FAULT (≥1)
CNT_W, 8, width of internal run/dead/filter counters; MIN_ON, DEAD, FAULT_FILT < 2^CNT_W

Ports:
clk_2  in  1  system clock
reset  in  1  synchronous, active-high reset
t1  in  1  temperature above lower threshold
t2  in  1  temperature above upper threshold
ack  in  1  fault acknowledge (level, sampled each edge)
heater  out  1  heater (aquecedor) enable, registered
cooler  out  1  cooler (refrigeração) enable, registered
fault  out  1  sensor-inconsistency indicator, registered
state  out  3  current FSM state code
n_starts  out  8  count of HEAT/COOL entries, wraps

Behaviour:
- Demand decode, combinational on current t1,t2: HEAT_REQ = ~t1&~t2; COOL_REQ = t1&t2; OK = t1&~t2; BAD = ~t1&t2.
- States/codes: IDLE=0, HEAT=1, COOL=2, DEAD=3, FAULT=4. heater=(state==HEAT), cooler=(state==COOL), fault=(state==FAULT). All three are decoded from the state register. Latency from input change to output is 1 edge.
- Reset, which overrides everything including FAULT: state=IDLE; run_cnt, dead_cnt, bad_cnt=0; n_starts=0; heater=cooler=fault=0.
- Fault filter:
  - bad_cnt increments on each BAD edge, saturating at FAULT_FILT; it clears on any non-BAD edge.
  - When BAD and bad_cnt==FAULT_FILT-1, the next state is FAULT from any non-FAULT state. This has highest priority and ignores MIN_ON.
- IDLE:
  - HEAT_REQ → HEAT.
  - COOL_REQ → COOL.
  - OK or sub-threshold BAD → stay.
  - Entering HEAT/COOL loads run_cnt=0 and increments n_starts (8-bit, 255→0).
- HEAT/COOL:
  - run_cnt increments each edge, saturating at MIN_ON-1.
  - Exit is allowed only at an edge where run_cnt==MIN_ON-1 and demand ≠ own request. It then goes → DEAD with dead_cnt=0.
  - The actuator is therefore high for ≥ MIN_ON cycles.
  - Opposite request never transitions directly; it always passes via DEAD then IDLE.
- DEAD:
  - dead_cnt increments each edge.
  - At the edge where dead_cnt==DEAD-1, go → IDLE, so DEAD lasts exactly DEAD cycles.
  - A FAULT entry still pre-empts.
- FAULT:
  - Actuators are off.
  - Stay while ack=0, or while ack=1 and BAD.
  - ack=1 with non-BAD → IDLE and bad_cnt=0.
- Invariants: heater&cooler never both 1; at most one of heater/cooler/fault is 1; state ∈ {0..4}.

Test Plan:
1. Reset, then t1=0,t2=0 for 1 cycle, then t1=1,t2=0 → heater=1 for exactly 4 cycles (edges 1–4), state=3 for 2 cycles, then state=0; n_starts=1.
2. HEAT running with t1=1,t2=1 asserted on cycle 2 → heater stays 1 until MIN_ON is met, 2 DEAD cycles, 1 IDLE cycle, then cooler=1; heater&cooler never 1; n_starts=2.
3. t1=0,t2=1 for 2 cycles, then OK → fault stays 0, bad_cnt clears. Then BAD for 3 cycles during HEAT with run_cnt=1 → fault=1 after 3rd edge, heater=0 on that same edge.
4. In FAULT: ack=1 with BAD held → stays FAULT. ack=1 with t1=1,t2=0 → state=0 next edge, fault=0. ack=1 while not in FAULT → no effect.
5. reset=1 for 1 edge mid-COOL (run_cnt=2) → cooler=0, state=0, n_starts=0 after that edge. Repeat reset during FAULT → fault=0.
6. 256 HEAT entries with minimal cycling → n_starts reads 255 then wraps to 0. Also run a MIN_ON=1, DEAD=1, FAULT_FILT=1 build: single BAD sample enters FAULT; HEAT lasts 1 cycle.
